ttt_game_engine: RTL and testbench
==================================

Name: ttt_game_engine

Overview:
- Parametrised successor to the fixed 3x3 tic-tac-toe datapath and control.
- Owns everything between the input buttons and the display for an N x N board with K-in-a-row win: cursor movement, two-player turn alternation, legal-move checking, 2-bit cell storage, and sequential win/draw detection.
- Feeds the display block through a flat board vector, the cursor index and a status field.

Parameters:
- BOARD_N, 3, board side length; legal range 3..8.
- WIN_K, 3, run length that wins; legal range 3..BOARD_N.
- IDX_W, $clog2(BOARD_N*BOARD_N), cell index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- dir  in  3  cursor direction: 000 idle, 001 up, 010 down, 011 right, 100 left; 101..111 are treated as idle.
- confirm  in  1  level from the place button; the engine edge-detects it internally.
- cursor  out  IDX_W  current cell index, row-major (row*BOARD_N + col).
- board  out  2*BOARD_N*BOARD_N  cell i sits at bits [2i+1:2i]; 00 empty, 01 player 1, 10 player 2.
- turn  out  1  player to move: 0 is player 1, 1 is player 2.
- busy  out  1  high while the win check runs; all input is ignored while busy.
- move_err  out  1  one-cycle pulse when confirm lands on an occupied cell.
- game_over  out  1  high in the DONE state.
- winner  out  2  00 undetermined, 01 player 1, 10 player 2, 11 draw.

Behaviour:
- Reset values: cursor=0, board=all 00, turn=0, busy=0, move_err=0, game_over=0, winner=00, move counter=0, FSM=WAIT.
- Reset wins over every other event in the same cycle, including mid-check and DONE.
- Cursor update (WAIT state only):
  - Registers move on a dir transition from idle to non-idle: one step per press, no auto-repeat.
  - Saturates at the board edges; there is no wrap-around.
  - dir is ignored in PLACE, CHECK and DONE.
- Confirm:
  - A rising edge of confirm in WAIT is a move request.
  - A confirm held across states does not re-trigger.
  - A rising edge of confirm and a dir press in the same cycle: the placement uses the pre-move cursor and the cursor then moves.
- FSM states:
  - WAIT: a move request on an empty cell goes to PLACE. A request on an occupied cell pulses move_err for 1 cycle and stays in WAIT; board and turn are unchanged.
  - PLACE (1 cycle): writes {turn==1, turn==0} into the cursor cell, increments the move counter, then goes to CHECK.
  - CHECK:
    - busy=1; scans every start cell s and each of 4 directions (E, S, SE, SW), one window per cycle.
    - A window is valid only if all K cells lie on the board.
    - A hit means all K cells equal the mover's code.
    - Hit: winner=mover, go to DONE.
    - Scan complete with no hit and move counter == N*N: winner=11, go to DONE.
    - Otherwise turn toggles and the FSM returns to WAIT.
    - Worst-case latency is 4*N*N cycles from PLACE to WAIT/DONE, fixed and not data-dependent except for early exit on a hit.
  - DONE: game_over=1; board, winner and cursor are frozen until reset.
- Widths: the move counter is $clog2(N*N+1) bits. Window index arithmetic is done in IDX_W+1 bits with an explicit bounds check, with no reliance on wrap.

Decomposition:
- Shared package ttt_pkg holds:
  - dir encodings: DIR_IDLE, DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT.
  - cell codes: CELL_EMPTY, CELL_P1, CELL_P2.
  - winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW.
  - FSM state enum: WAIT, PLACE, CHECK, DONE.
- One natural sub-module, ttt_line_checker:
  - Combinational.
  - Inputs: board, start index, direction, player code.
  - Outputs: valid and hit for one K-window.
  - The engine instantiates it once and sequences it with the scan counters.

Test Plan:
- Reset, then press right twice and down once (N=3) -> cursor=5; a further right press -> cursor stays 5; holding dir for 10 cycles moves only one step.
- P1 places at cell 0, P2 tries cell 0 -> move_err pulses 1 cycle, board[1:0] stays 01, turn stays 1.
- Play P1 at 0, 4, 8 with P2 at 1, 2 -> after the last CHECK, winner=01, game_over=1; later confirm and dir inputs leave board and cursor unchanged.
- Fill a 3x3 board in a drawn pattern (P1: 0,2,3,7,8; P2: 1,4,5,6) -> after the 9th move, winner=11, game_over=1, and busy was high for exactly 36 cycles.
- BOARD_N=5, WIN_K=4, P2 fills anti-diagonal cells 4,8,12,16 -> winner=10. A 3-run near the edge does not win, and no window reads off-board.
- Assert reset during CHECK -> the next cycle shows board=0, busy=0, turn=0, winner=00, FSM in WAIT.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe engine: button directions, cell and
// winner codes, controller states and the four scan directions.
package ttt_pkg;

  // Cursor button encodings; 101..111 behave like idle
  localparam logic [2:0] DIR_IDLE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_RIGHT = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b100;

  // Two-bit cell contents
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // Game result
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    WAIT  = 2'b00,
    PLACE = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Window directions, in scan order
  typedef enum logic [1:0] {
    LINE_E  = 2'b00,
    LINE_S  = 2'b01,
    LINE_SE = 2'b10,
    LINE_SW = 2'b11
  } line_dir_t;

  // True for the four codes that actually move the cursor
  function automatic logic dir_active(input logic [2:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_RIGHT) || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Evaluates one K-long window of the board: whether it fits on the board and
// whether every cell in it holds the given player code.
module ttt_line_checker
  import ttt_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int WIN_K   = 3,
  localparam int CELLS  = BOARD_N * BOARD_N,
  localparam int IDX_W  = $clog2(CELLS)
) (
  input  logic [2*CELLS-1:0] board,
  input  logic [IDX_W-1:0]   start,
  input  line_dir_t          line_dir,
  input  logic [1:0]         player,
  output logic               valid,
  output logic               hit
);

  // One extra bit so index sums never wrap before the bounds check
  localparam int AW = IDX_W + 1;
  localparam logic [AW-1:0] N_A     = AW'(BOARD_N);
  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);
  localparam logic [AW-1:0] SPAN_A  = AW'(WIN_K - 1);

  logic [1:0]    cells [CELLS];
  logic [AW-1:0] start_a;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [AW-1:0] step;
  logic [AW-1:0] idx;
  logic          all_match;

  for (genvar g = 0; g < CELLS; g++) begin : g_unpack
    assign cells[g] = board[2*g +: 2];
  end

  // Window geometry, on-board test and cell-by-cell compare
  always_comb begin
    start_a = {1'b0, start};
    row     = start_a / N_A;
    col     = start_a % N_A;
    step    = '0;
    valid   = 1'b0;
    case (line_dir)
      LINE_E: begin
        step  = AW'(1);
        valid = (col + SPAN_A) < N_A;
      end
      LINE_S: begin
        step  = N_A;
        valid = (row + SPAN_A) < N_A;
      end
      LINE_SE: begin
        step  = N_A + AW'(1);
        valid = ((row + SPAN_A) < N_A) && ((col + SPAN_A) < N_A);
      end
      LINE_SW: begin
        step  = N_A - AW'(1);
        valid = ((row + SPAN_A) < N_A) && (col >= SPAN_A);
      end
      default: begin
        step  = '0;
        valid = 1'b0;
      end
    endcase
    if (start_a >= CELLS_A) valid = 1'b0;

    all_match = 1'b1;
    idx       = start_a;
    for (int k = 0; k < WIN_K; k++) begin
      // Never read a cell past the end of the board
      if (idx < CELLS_A) begin
        if (cells[idx[IDX_W-1:0]] != player) all_match = 1'b0;
      end else begin
        all_match = 1'b0;
      end
      idx = idx + step;
    end
    hit = valid && all_match;
  end

endmodule

// File: rtl/ttt_game_engine.sv
// N x N, K-in-a-row tic-tac-toe engine: cursor, turn handling, placement and
// a sequential win/draw scan of every window, one window per cycle.
//
// Handshake: there is no valid/ready pair. confirm and dir are levels that are
// edge-detected internally and only acted on in WAIT; busy marks the CHECK scan
// during which every input edge is dropped, and move_err is a one-cycle pulse.
module ttt_game_engine
  import ttt_pkg::*;
#(
  parameter int BOARD_N = 3,
  parameter int WIN_K   = 3,
  localparam int CELLS  = BOARD_N * BOARD_N,
  localparam int IDX_W  = $clog2(CELLS),
  localparam int CNT_W  = $clog2(CELLS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         dir,
  input  logic               confirm,
  output logic [IDX_W-1:0]   cursor,
  output logic [2*CELLS-1:0] board,
  output logic               turn,
  output logic               busy,
  output logic               move_err,
  output logic               game_over,
  output logic [1:0]         winner,
  output state_t             fsm_state
);

  localparam logic [IDX_W-1:0] N_I      = IDX_W'(BOARD_N);
  localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0] BOTTOM_I = IDX_W'(CELLS - BOARD_N);
  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(CELLS);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       cells_q [CELLS];
  logic [CNT_W-1:0] move_cnt;
  logic [IDX_W-1:0] place_idx;
  logic [IDX_W-1:0] scan_cell;
  line_dir_t        scan_dir;
  logic [IDX_W-1:0] cursor_next;
  logic [IDX_W-1:0] cur_col;
  logic             dir_act_q;
  logic             conf_q;
  logic             dir_press;
  logic             place_req;
  logic             cur_empty;
  logic             scan_last;
  logic             lc_valid;
  logic             lc_hit;
  logic             window_hit;
  logic [1:0]       mover;

  for (genvar g = 0; g < CELLS; g++) begin : g_pack
    assign board[2*g +: 2] = cells_q[g];
  end

  assign mover      = turn ? CELL_P2 : CELL_P1;
  assign dir_press  = dir_active(dir) && !dir_act_q;
  assign place_req  = (state_q == WAIT) && confirm && !conf_q;
  assign cur_empty  = (cells_q[cursor] == CELL_EMPTY);
  assign scan_last  = (scan_cell == LAST_I) && (scan_dir == LINE_SW);
  assign window_hit = lc_valid && lc_hit;
  assign busy       = (state_q == CHECK);
  assign game_over  = (state_q == DONE);
  assign fsm_state  = state_q;

  ttt_line_checker #(
    .BOARD_N (BOARD_N),
    .WIN_K   (WIN_K)
  ) u_line_checker (
    .board    (board),
    .start    (scan_cell),
    .line_dir (scan_dir),
    .player   (mover),
    .valid    (lc_valid),
    .hit      (lc_hit)
  );

  // Saturating one-step cursor move for the current dir code
  always_comb begin
    cur_col     = cursor % N_I;
    cursor_next = cursor;
    case (dir)
      DIR_UP:    if (cursor >= N_I) cursor_next = cursor - N_I;
      DIR_DOWN:  if (cursor < BOTTOM_I) cursor_next = cursor + N_I;
      DIR_RIGHT: if (cur_col != (N_I - IDX_W'(1))) cursor_next = cursor + IDX_W'(1);
      DIR_LEFT:  if (cur_col != '0) cursor_next = cursor - IDX_W'(1);
      default:   cursor_next = cursor;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:  if (place_req && cur_empty) state_d = PLACE;
      PLACE: state_d = CHECK;
      CHECK: begin
        if (window_hit)     state_d = DONE;
        else if (scan_last) state_d = (move_cnt == FULL_C) ? DONE : WAIT;
      end
      DONE:    state_d = DONE;
      default: state_d = WAIT;
    endcase
  end

  // Datapath: edge detectors, cursor, board, turn, scan counters and result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) cells_q[i] <= CELL_EMPTY;
      cursor    <= '0;
      turn      <= 1'b0;
      move_err  <= 1'b0;
      winner    <= WIN_NONE;
      move_cnt  <= '0;
      place_idx <= '0;
      scan_cell <= '0;
      scan_dir  <= LINE_E;
      dir_act_q <= 1'b0;
      conf_q    <= 1'b0;
    end else begin
      // Edge history runs in every state so a held button never re-fires
      dir_act_q <= dir_active(dir);
      conf_q    <= confirm;
      move_err  <= 1'b0;
      case (state_q)
        WAIT: begin
          // The placement target is captured before the cursor moves
          if (place_req) begin
            if (cur_empty) place_idx <= cursor;
            else           move_err  <= 1'b1;
          end
          if (dir_press) cursor <= cursor_next;
        end
        PLACE: begin
          cells_q[place_idx] <= mover;
          move_cnt  <= move_cnt + CNT_W'(1);
          scan_cell <= '0;
          scan_dir  <= LINE_E;
        end
        CHECK: begin
          if (window_hit) begin
            winner <= turn ? WIN_P2 : WIN_P1;
          end else if (scan_last) begin
            if (move_cnt == FULL_C) winner <= WIN_DRAW;
            else                    turn   <= ~turn;
          end else if (scan_dir == LINE_SW) begin
            scan_dir  <= LINE_E;
            scan_cell <= scan_cell + IDX_W'(1);
          end else begin
            scan_dir  <= line_dir_t'(scan_dir + 2'd1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_engine.sv
// Bench for the tic-tac-toe engine: a 3x3/K=3 instance and a 5x5/K=4 instance
// share dir/confirm; the idle one is held in reset.
module tb_ttt_game_engine;
  import ttt_pkg::*;

  logic clk = 1'b0;
  logic reset3, reset5, confirm, sel;
  logic [2:0] dir;

  logic [3:0]  cursor3;
  logic [17:0] board3;
  logic        turn3, busy3, err3, go3;
  logic [1:0]  win3;
  state_t      st3;

  logic [4:0]  cursor5;
  logic [49:0] board5;
  logic        turn5, busy5, err5, go5;
  logic [1:0]  win5;
  state_t      st5;

  logic [7:0]  o_cursor;
  logic [63:0] o_board;
  logic        o_turn, o_busy, o_err, o_go;
  logic [1:0]  o_win;
  state_t      o_state;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n, k, m_moves, cur_pos;
  int m_cells[64];
  logic m_turn;

  // Clock
  always #5 clk = ~clk;

  ttt_game_engine #(.BOARD_N(3), .WIN_K(3)) u_dut3 (
    .clk(clk), .reset(reset3), .dir(dir), .confirm(confirm),
    .cursor(cursor3), .board(board3), .turn(turn3), .busy(busy3),
    .move_err(err3), .game_over(go3), .winner(win3), .fsm_state(st3)
  );

  ttt_game_engine #(.BOARD_N(5), .WIN_K(4)) u_dut5 (
    .clk(clk), .reset(reset5), .dir(dir), .confirm(confirm),
    .cursor(cursor5), .board(board5), .turn(turn5), .busy(busy5),
    .move_err(err5), .game_over(go5), .winner(win5), .fsm_state(st5)
  );

  assign o_cursor = sel ? 8'(cursor5) : 8'(cursor3);
  assign o_board  = sel ? 64'(board5) : 64'(board3);
  assign o_turn   = sel ? turn5 : turn3;
  assign o_busy   = sel ? busy5 : busy3;
  assign o_err    = sel ? err5 : err3;
  assign o_go     = sel ? go5 : go3;
  assign o_win    = sel ? win5 : win3;
  assign o_state  = sel ? st5 : st3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Ordinal (1-based, scan order cell*4+dir) of the first winning window, 0 if none
  function automatic int first_hit(input int p);
    int res, dr, dc, r, c, ok;
    res = 0;
    for (int s = 0; s < n*n; s++) begin
      for (int d = 0; d < 4; d++) begin
        dr = (d == 0) ? 0 : 1;
        dc = (d == 0 || d == 2) ? 1 : ((d == 1) ? 0 : -1);
        ok = 1;
        for (int j = 0; j < k; j++) begin
          r = s / n + j * dr;
          c = s % n + j * dc;
          if (r < 0 || r >= n || c < 0 || c >= n) ok = 0;
          else if (m_cells[r*n + c] != p) ok = 0;
        end
        if (ok == 1 && res == 0) res = s * 4 + d + 1;
      end
    end
    return res;
  endfunction

  function automatic logic [63:0] model_board();
    logic [63:0] b;
    logic [1:0]  v;
    b = '0;
    for (int i = 0; i < n*n; i++) begin
      v = 2'(m_cells[i]);
      b[2*i +: 2] = v;
    end
    return b;
  endfunction

  function automatic void model_move(input logic [2:0] d);
    int r, c;
    r = cur_pos / n;
    c = cur_pos % n;
    if (d == DIR_UP && r > 0) r--;
    else if (d == DIR_DOWN && r < n - 1) r++;
    else if (d == DIR_RIGHT && c < n - 1) c++;
    else if (d == DIR_LEFT && c > 0) c--;
    cur_pos = r * n + c;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_cursor"}, o_cursor, 0);
    check({tag, "_board"}, o_board, 0);
    check({tag, "_turn"}, o_turn, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_over"}, o_go, 0);
    check({tag, "_winner"}, o_win, WIN_NONE);
    check({tag, "_state"}, o_state, WAIT);
  endtask

  // One-cycle reset of the selected instance, then model reset
  task automatic new_game(input string tag);
    @(negedge clk);
    if (sel) reset5 = 1'b1; else reset3 = 1'b1;
    @(negedge clk);
    check_reset(tag);
    reset3 = sel;
    reset5 = !sel;
    for (int i = 0; i < 64; i++) m_cells[i] = 0;
    m_moves = 0;
    m_turn  = 1'b0;
    cur_pos = 0;
  endtask

  task automatic press(input logic [2:0] d);
    @(negedge clk);
    dir = d;
    @(negedge clk);
    dir = DIR_IDLE;
  endtask

  task automatic goto_cell(input int t);
    while (cur_pos / n < t / n) begin press(DIR_DOWN);  cur_pos += n; end
    while (cur_pos / n > t / n) begin press(DIR_UP);    cur_pos -= n; end
    while (cur_pos % n < t % n) begin press(DIR_RIGHT); cur_pos += 1; end
    while (cur_pos % n > t % n) begin press(DIR_LEFT);  cur_pos -= 1; end
  endtask

  task automatic wait_settle(output int bc);
    int guard;
    bc = 0;
    guard = 0;
    while (!(o_state == WAIT || o_state == DONE) && guard < 300) begin
      if (o_busy) bc++;
      guard++;
      @(negedge clk);
    end
    check("settle_bound", guard < 300, 1);
  endtask

  // Legal move at t; optional dir pressed together with confirm
  task automatic place_move(input int t, input logic [2:0] d);
    int code, hit, ebusy, bc;
    logic [1:0] ew;
    logic ego, eturn;
    logic [63:0] e, mb;
    goto_cell(t);
    code = m_turn ? 2 : 1;
    m_cells[t] = code;
    m_moves++;
    hit = first_hit(code);
    if (hit != 0) begin
      ew = 2'(code); ego = 1'b1; eturn = m_turn; ebusy = hit;
    end else if (m_moves == n*n) begin
      ew = WIN_DRAW; ego = 1'b1; eturn = m_turn; ebusy = 4*n*n;
    end else begin
      ew = WIN_NONE; ego = 1'b0; m_turn = !m_turn; eturn = m_turn; ebusy = 4*n*n;
    end
    mb = model_board();
    exp_q.push_back({8'(ebusy), ew, ego, eturn, mb[51:0]});
    model_move(d);
    @(negedge clk);
    confirm = 1'b1;
    dir = d;
    @(negedge clk);
    confirm = 1'b0;
    dir = DIR_IDLE;
    wait_settle(bc);
    e = exp_q.pop_front();
    check("busy_cycles", 64'(bc), 64'(e[63:56]));
    check("winner", o_win, e[55:54]);
    check("game_over", o_go, e[53]);
    check("turn", o_turn, e[52]);
    check("board", o_board, {12'b0, e[51:0]});
    check("cursor", o_cursor, cur_pos);
  endtask

  task automatic place_occupied();
    @(negedge clk);
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    check("err_pulse", o_err, 1);
    @(negedge clk);
    check("err_clear", o_err, 0);
    check("err_state", o_state, WAIT);
    check("err_board", o_board, model_board());
    check("err_turn", o_turn, m_turn);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; reset3 = 1'b1; reset5 = 1'b1; confirm = 1'b0; dir = DIR_IDLE;
    n = 3; k = 3; m_moves = 0; m_turn = 1'b0; cur_pos = 0;
    for (int i = 0; i < 64; i++) m_cells[i] = 0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset3 = 1'b0;

    // Cursor: right, right, down -> 5; saturate right; held dir moves once
    press(DIR_RIGHT); press(DIR_RIGHT); press(DIR_DOWN);
    @(negedge clk); check("cur_5", o_cursor, 5);
    press(DIR_RIGHT);
    @(negedge clk); check("cur_sat_right", o_cursor, 5);
    @(negedge clk); dir = DIR_DOWN;
    repeat (10) @(negedge clk);
    dir = DIR_IDLE;
    @(negedge clk); check("cur_hold", o_cursor, 8);
    press(3'b101);
    @(negedge clk); check("cur_dir_101", o_cursor, 8);
    for (int i = 0; i < 3; i++) press(DIR_LEFT);
    @(negedge clk); check("cur_sat_left", o_cursor, 6);
    for (int i = 0; i < 3; i++) press(DIR_UP);
    @(negedge clk); check("cur_sat_up", o_cursor, 0);
    cur_pos = 0;

    // Game 1: occupied-cell error then P1 diagonal win
    place_move(0, DIR_IDLE);
    place_occupied();
    place_move(1, DIR_IDLE);
    place_move(4, DIR_IDLE);
    place_move(2, DIR_IDLE);
    place_move(8, DIR_IDLE);
    press(DIR_LEFT);
    @(negedge clk); confirm = 1'b1;
    @(negedge clk); confirm = 1'b0;
    repeat (3) @(negedge clk);
    check("done_cursor", o_cursor, 8);
    check("done_board", o_board, model_board());
    check("done_winner", o_win, WIN_P1);
    check("done_state", o_state, DONE);

    // Reset from DONE, then reset in the middle of CHECK
    new_game("rst_done");
    goto_cell(4);
    @(negedge clk); confirm = 1'b1;
    @(negedge clk); confirm = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", o_busy, 1);
    new_game("rst_check");

    // Game 2: draw; first move also presses right
    place_move(0, DIR_RIGHT);
    place_move(1, DIR_IDLE);
    place_move(2, DIR_IDLE);
    place_move(4, DIR_IDLE);
    place_move(3, DIR_IDLE);
    place_move(5, DIR_IDLE);
    place_move(7, DIR_IDLE);
    place_move(6, DIR_IDLE);
    place_move(8, DIR_IDLE);
    check("draw_winner", o_win, WIN_DRAW);

    // Game 3: 5x5, K=4; row-wrapping P1 cells and a P2 anti-diagonal
    reset3 = 1'b1;
    sel = 1'b1;
    n = 5; k = 4;
    new_game("rst5");
    place_move(18, DIR_IDLE);
    place_move(4, DIR_IDLE);
    place_move(19, DIR_IDLE);
    place_move(8, DIR_IDLE);
    place_move(20, DIR_IDLE);
    place_move(12, DIR_IDLE);
    place_move(21, DIR_IDLE);
    place_move(16, DIR_IDLE);
    check("n5_winner", o_win, WIN_P2);
    check("q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
